// File: rtl/fft_bin_serializer.sv
// fft_bin_serializer: reorders a bit-reversed 16-bin FFT frame into natural order, narrows 16.16 to saturated 8.8, streams one bin per beat
// Ports: clk/rst (sync, active-high); in_real/in_imag lane k = bin bitrev4(k); in_valid/in_ready frame handshake;
//        out_data {re,im} 8.8, out_index bin number, out_last on bin 15, out_valid/out_ready beat handshake;
//        frame_cnt completed output frames (wraps at 256).
module fft_bin_serializer #(
    parameter int N         = 16,
    parameter int IN_W      = 32,
    parameter int OUT_W     = 16,
    parameter int FRAC_DROP = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*IN_W-1:0]    in_real,
    input  logic [N*IN_W-1:0]    in_imag,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*OUT_W-1:0]   out_data,
    output logic [3:0]           out_index,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           frame_cnt
);
    typedef enum logic {IDLE, STREAM} state_t;
    localparam logic signed [IN_W-1:0] SAT_HI = IN_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W-1:0] SAT_LO = -SAT_HI - 1;
    state_t state, state_nx;
    logic [2*OUT_W-1:0] mem [2][N];
    logic [2*OUT_W-1:0] nar [N];
    logic [1:0] full;
    logic wb, rb, accept, hs, last;
    logic [3:0] beat;
    function automatic logic [OUT_W-1:0] narrow(input logic [IN_W-1:0] v);
        logic signed [IN_W-1:0] t;
        t = $signed(v) >>> FRAC_DROP;
        return t > SAT_HI ? SAT_HI[OUT_W-1:0] : t < SAT_LO ? SAT_LO[OUT_W-1:0] : t[OUT_W-1:0];
    endfunction
    // Lane k lands in natural-order slot bitrev4(k).
    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam int R = ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
        assign nar[R] = {narrow(in_real[k*IN_W +: IN_W]), narrow(in_imag[k*IN_W +: IN_W])};
    end
    assign in_ready  = !full[wb];
    assign accept    = in_valid && in_ready;
    assign out_valid = state == STREAM;
    assign hs        = out_valid && out_ready;
    assign last      = beat == 4'hF;
    assign out_data  = out_valid ? mem[rb][beat] : '0;
    assign out_index = beat;
    assign out_last  = out_valid && last;
    always_ff @(posedge clk)
        if (accept) mem[wb] <= nar;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    // Back-to-back frames continue without a bubble only if the other bank was already full.
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (full[rb] ? STREAM : IDLE)
                 : (hs && last) ? (full[!rb] ? STREAM : IDLE) : STREAM;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= '0;
            wb        <= 1'b0;
            rb        <= 1'b0;
            beat      <= '0;
            frame_cnt <= '0;
        end else begin
            if (accept) begin
                full[wb] <= 1'b1;
                wb       <= !wb;
            end
            if (hs) beat <= beat + 4'd1;
            if (hs && last) begin
                full[rb]  <= 1'b0;
                rb        <= !rb;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
endmodule

// File: doc/fft_bin_serializer.md
Name: fft_bin_serializer

Overview:
- Consumer end of the 16-point FFT datapath: accepts one full frame of 16 complex bins in parallel and streams them out one bin per beat in natural frequency order.
- Lanes arrive in bit-reversed order (the DIF layers' output order). This block reorders them, narrows each 16.16 component to a saturated 8.8 value, and handles backpressure through a two-bank ping-pong buffer.
- Sits between the final butterfly layer and the result write-back / testbench output port.

Parameters:
- N, 16, bins per frame; must be 16 (4-bit index); the parameter exists only for checking.
- IN_W, 32, width of each input real/imag component, signed 16.16 fixed point.
- OUT_W, 16, width of each output component, signed 8.8 fixed point.
- FRAC_DROP, 8, fractional LSBs discarded when narrowing.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_real  in  N*IN_W  lane k at bits [k*IN_W +: IN_W] holds the real part of bin bitrev4(k)
- in_imag  in  N*IN_W  same lane layout, imaginary part
- in_valid  in  1  frame present on in_real/in_imag
- in_ready  out  1  a bank is free; a frame is accepted when in_valid && in_ready
- out_data  out  2*OUT_W  {real8.8, imag8.8} of the current bin
- out_index  out  4  natural-order bin number of out_data
- out_last  out  1  high with bin 15
- out_valid  out  1  out_data is valid
- out_ready  in  1  sink accepts a beat when out_valid && out_ready
- frame_cnt  out  8  number of completed output frames, wraps at 256

Behaviour:
- Storage: two banks (A, B), each 16 x 2*OUT_W, plus per-bank FULL flag, write pointer wb, read pointer rb, and a 4-bit beat counter.
- Narrowing, applied at load time per component:
  - t = v >>> FRAC_DROP (arithmetic shift, truncation toward -inf, no rounding).
  - If t > 32767, store 16'h7FFF. If t < -32768, store 16'h8000. Otherwise store t[15:0].
- Load:
  - in_ready = !FULL[wb].
  - On accept, all 16 lanes are written in one cycle: bank[wb][bitrev4(k)] = narrowed lane k.
  - Set FULL[wb]; toggle wb.
  - Input is not sampled while in_ready is low.
- Read FSM:
  - States IDLE and STREAM.
  - IDLE: out_valid = 0. Move to STREAM on the cycle after FULL[rb] becomes 1, with beat = 0.
  - STREAM: out_valid = 1, out_index = beat, out_data = bank[rb][beat], out_last = (beat == 15).
  - On a handshake: beat increments.
  - On a handshake with beat == 15:
    - clear FULL[rb], toggle rb, increment frame_cnt;
    - if the other bank is FULL, stay in STREAM with beat = 0 and no bubble;
    - otherwise go to IDLE.
  - Output stability: while out_valid && !out_ready, out_data, out_index and out_last hold constant.
- Latency: a frame accepted at edge T into an empty block presents bin 0 in the cycle after edge T+1 (out_valid rises two edges after acceptance). Throughput is 16 beats per frame.
- Simultaneous events:
  - Accept into bank X and last read beat of the other bank in the same cycle: both take effect; no flag conflict because the banks differ.
  - The last read beat frees a bank in the same cycle in_valid is high: in_ready follows the registered FULL flags, so the frame is accepted the following cycle. A bank freed at edge T is reusable from T+1.
- Full condition: both banks FULL means in_ready = 0 until the last beat of the current read bank completes.
- Reset (also mid-frame): FULL = 0/0, wb = rb = 0, beat = 0, state IDLE, out_valid = 0, out_data = 0, out_index = 0, out_last = 0, frame_cnt = 0, in_ready = 1 on the first cycle after reset. Partial frames are discarded. Bank contents need not be cleared.

Test Plan:
- Single frame, lane k real = (k<<16), imag = -(k<<16), out_ready tied 1 -> 16 beats; beat i has out_index = i, real = bitrev4(i)<<8, imag = -(bitrev4(i)<<8); out_last only on i = 15; frame_cnt = 1.
- Saturation: lane 0 real = 32'h7FFF_FFFF, imag = 32'h8000_0000; lane 1 real = 32'h0000_01FF -> bin 0 = {16'h7FFF, 16'h8000}; bin 8 real = 16'h0001.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> no beat lost or duplicated; out_data stable during stalls; all 16 bins in order.
- Ping-pong: three frames offered back to back, out_ready = 1 -> frames 1 and 2 accepted on consecutive cycles; frame 3 stalls (in_ready = 0) until frame 1's beat 15 completes; 48 beats with no bubble between frames; frame_cnt = 3.
- Reset mid-stream at beat 7 of frame 1, with frame 2 buffered -> next cycle out_valid = 0, in_ready = 1, frame_cnt = 0; a new frame then streams normally from bin 0.
- frame_cnt wrap: 256 frames -> frame_cnt returns to 0.
